minv_reg_seq: RTL and testbench
===============================

Name: minv_reg_seq

Overview:
- Control sequencer that sits directly upstream of the 256-bit inversion working register.
- Accepts a 256-bit operand as 16-bit words over a valid/ready stream and drives the register's we/sel_cyc/sel_rs/regin pins.
- Grants single-bit right-shift requests from the inversion core.
- Unloads the result as 16-bit words by cyclic rotation, which leaves register contents intact after a full unload.

Parameters:
- W, 16, word width; equals the register's regin width.
- NWORDS, 16, words per operand (256/W).
- CW, 5, word-counter width; must satisfy CW >= clog2(NWORDS+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  load word valid.
- in_ready  out  1  load word accept.
- in_data  in  W  load word; least-significant word first.
- load_done  out  1  one-cycle pulse after word NWORDS-1 is accepted.
- rs_req  in  1  core request: shift register right 1 bit this cycle.
- unload_start  in  1  begin result readout.
- out_valid  out  1  readout word valid.
- out_ready  in  1  readout word accept.
- out_data  out  W  readout word (= reg_lsw).
- out_last  out  1  high with the final readout word.
- unload_done  out  1  one-cycle pulse after the final readout word is accepted.
- flush  in  1  synchronous abort to IDLE.
- reg_din  out  W  to register regin; equals in_data.
- reg_we  out  1  to register we.
- reg_sel_cyc  out  1  to register sel_cyc.
- reg_sel_rs  out  1  to register sel_rs.
- reg_lsw  in  W  from register regout[W-1:0].
- rs_count  out  16  shift counter (optional feature; 0 when disabled).

Behaviour:
- Clocking/reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: state=IDLE, cnt=0, load_done=0, unload_done=0, rs_count=0. The register contents are not reset.
- States: IDLE, LOAD, HOLD, UNLOAD. cnt counts words.
- IDLE/LOAD:
  - in_ready=1.
  - On accept: reg_we=1, sel_cyc=0, sel_rs=0; cnt++; IDLE->LOAD on the first word.
  - On accepting word NWORDS-1: ->HOLD, cnt=0, load_done=1 on the next cycle only.
- HOLD:
  - in_ready=0.
  - rs_req=1: reg_we=1, sel_rs=1, sel_cyc=0.
  - unload_start=1 with rs_req=0: ->UNLOAD. If both are high, rs_req wins and unload_start is ignored that cycle.
- UNLOAD:
  - out_valid=1, out_data=reg_lsw (combinational).
  - On out_ready: reg_we=1, sel_cyc=1, sel_rs=0; cnt++.
  - out_last=1 when cnt=NWORDS-1. Its accept gives ->HOLD, cnt=0, unload_done=1 next cycle.
  - rs_req is ignored outside HOLD.
- Control outputs:
  - reg_we, reg_sel_*, in_ready, out_valid, out_last and out_data are combinational from state and handshakes. No latency is added to the register path.
  - reg_we=0 in all other cases; sel_* are don't-care when reg_we=0 and are driven 0.
  - out_valid stays high and out_data stable until out_ready (standard valid/ready; no retraction).
- flush:
  - Has priority over all handshakes.
  - Forces reg_we=0 that cycle, then ->IDLE, cnt=0.
  - A partially loaded operand is discarded and a partial unload leaves the register rotated.
- Reset mid-operation: same as flush; the register is left as-is.
- Boundaries:
  - in_valid in HOLD/UNLOAD is not accepted.
  - unload_start in IDLE/LOAD is ignored.
  - A back-to-back load_done cycle may accept rs_req immediately.

Optional Feature:
- Macro MINV_SEQ_RSCNT_EN.
- Defined: rs_count increments on each granted rs_req and saturates at 16'hFFFF. It clears on reset, flush, and the cycle load_done asserts; it holds otherwise.
- Undefined: rs_count is tied to 0 and no counter flops are built.

Test Plan:
- Load 16 words 0x0001..0x0010, in_valid held high -> 16 reg_we pulses with sel_cyc=0; load_done on cycle 17; in_ready=0 afterwards.
- Load with in_valid toggling every other cycle -> exactly 16 accepts over 31 cycles; load_done once.
- HOLD, rs_req high for 3 cycles -> 3 cycles of reg_we=1/sel_rs=1; with feature on, rs_count=3.
- Unload with register model holding words 0x1111..0x0F0F+ and out_ready toggling -> out_data sequence equals model LSW first; out_last on word 16; unload_done once; register model unchanged.
- unload_start and rs_req high together in HOLD -> shift only, state stays HOLD.
- flush after 7 loaded words, then rst_n=0 mid-UNLOAD -> IDLE, cnt=0, no reg_we on the flush cycle; a fresh 16-word load then completes normally.

Source files
------------

// File: rtl/minv_reg_seq.sv
// minv_reg_seq: control sequencer for the 256-bit inversion working register.
//
// Loads an operand as NWORDS words of W bits over a valid/ready stream (LSW
// first), grants single-bit right-shift requests from the inversion core, and
// unloads the result LSW first by cyclic word rotation. A full unload
// therefore leaves the register contents unchanged.
//
// Optional feature: define MINV_SEQ_RSCNT_EN to build a saturating 16-bit
// counter of granted shifts on rs_count. When undefined, rs_count is tied to 0.
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   in_valid/in_ready    load word handshake, in_data carries the word
//   load_done            one-cycle pulse after the last load word is accepted
//   rs_req               core request for a 1-bit right shift (HOLD only)
//   unload_start         begin result readout (HOLD only)
//   out_valid/out_ready  readout handshake, out_data = reg_lsw
//   out_last             marks the final readout word
//   unload_done          one-cycle pulse after the final readout word
//   flush                synchronous abort to IDLE
//   reg_din/reg_we/reg_sel_cyc/reg_sel_rs  register control pins
//   reg_lsw              register regout[W-1:0]
//   rs_count             granted shift count (0 when the feature is off)
module minv_reg_seq #(
    parameter int unsigned W      = 16,
    parameter int unsigned NWORDS = 16,
    parameter int unsigned CW     = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         load_done,
    input  logic         rs_req,
    input  logic         unload_start,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         unload_done,
    input  logic         flush,
    output logic [W-1:0] reg_din,
    output logic         reg_we,
    output logic         reg_sel_cyc,
    output logic         reg_sel_rs,
    input  logic [W-1:0] reg_lsw,
    output logic [15:0]  rs_count
);

    localparam logic [CW-1:0] LAST_WORD = CW'(NWORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_load_done;
    logic          w_load_done_nxt;
    logic          r_unload_done;
    logic          w_unload_done_nxt;
    logic          w_abort;

    // Data paths are pure wiring: no latency between stream and register.
    assign reg_din     = in_data;
    assign out_data    = reg_lsw;
    assign load_done   = r_load_done;
    assign unload_done = r_unload_done;

    // A reset cycle behaves like a flush: no register write, return to IDLE.
    assign w_abort = flush | ~rst_n;

    // Next-state and combinational control outputs.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_load_done_nxt   = 1'b0;
        w_unload_done_nxt = 1'b0;
        in_ready          = 1'b0;
        out_valid         = 1'b0;
        out_last          = 1'b0;
        reg_we            = 1'b0;
        reg_sel_cyc       = 1'b0;
        reg_sel_rs        = 1'b0;

        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        reg_we = 1'b1;
                        if (r_cnt == LAST_WORD) begin
                            w_state_nxt     = ST_HOLD;
                            w_cnt_nxt       = '0;
                            w_load_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_LOAD;
                            w_cnt_nxt   = r_cnt + CW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // Shift request wins over a simultaneous unload_start.
                    if (rs_req) begin
                        reg_we     = 1'b1;
                        reg_sel_rs = 1'b1;
                    end else if (unload_start) begin
                        w_state_nxt = ST_UNLOAD;
                    end
                end
                ST_UNLOAD: begin
                    out_valid = 1'b1;
                    out_last  = (r_cnt == LAST_WORD);
                    if (out_ready) begin
                        reg_we      = 1'b1;
                        reg_sel_cyc = 1'b1;
                        if (r_cnt == LAST_WORD) begin
                            w_state_nxt       = ST_HOLD;
                            w_cnt_nxt         = '0;
                            w_unload_done_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, word counter and done pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_load_done   <= 1'b0;
            r_unload_done <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_load_done   <= w_load_done_nxt;
            r_unload_done <= w_unload_done_nxt;
        end
    end

`ifdef MINV_SEQ_RSCNT_EN
    logic [15:0] r_rs_count;

    // Saturating count of granted shifts; reg_sel_rs is high exactly on a grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rs_count <= '0;
        end else if (flush || w_load_done_nxt) begin
            r_rs_count <= '0;
        end else if (reg_sel_rs && (r_rs_count != 16'hFFFF)) begin
            r_rs_count <= r_rs_count + 16'd1;
        end
    end

    assign rs_count = r_rs_count;
`else
    assign rs_count = '0;
`endif

endmodule

// File: tb/tb_minv_reg_seq.sv
// Self-checking bench for minv_reg_seq. A behavioural 256-bit register model
// responds to the sequencer's control pins; expected operand contents, readout
// words and shift counts are derived from the load/shift/rotate semantics.
module tb_minv_reg_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        load_done;
    logic        rs_req;
    logic        unload_start;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        unload_done;
    logic        flush;
    logic [15:0] reg_din;
    logic        reg_we;
    logic        reg_sel_cyc;
    logic        reg_sel_rs;
    logic [15:0] reg_lsw;
    logic [15:0] rs_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [255:0] reg_model = '0;
    logic [255:0] exp_op    = '0;
    int           exp_rs    = 0;
    int           n_ld_mon  = 0;
    int           n_ud_mon  = 0;

    minv_reg_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .load_done    (load_done),
        .rs_req       (rs_req),
        .unload_start (unload_start),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .unload_done  (unload_done),
        .flush        (flush),
        .reg_din      (reg_din),
        .reg_we       (reg_we),
        .reg_sel_cyc  (reg_sel_cyc),
        .reg_sel_rs   (reg_sel_rs),
        .reg_lsw      (reg_lsw),
        .rs_count     (rs_count)
    );

    always #5 clk = ~clk;

    // Working register model: load shifts a word in at the top, cyclic mode
    // rotates right by one word, shift mode shifts right one bit (zero fill).
    assign reg_lsw = reg_model[15:0];
    always @(posedge clk) begin
        if (reg_we === 1'b1) begin
            if (reg_sel_rs === 1'b1)       reg_model <= reg_model >> 1;
            else if (reg_sel_cyc === 1'b1) reg_model <= {reg_model[15:0], reg_model[255:16]};
            else                           reg_model <= {reg_din, reg_model[255:16]};
        end
    end

    // Pulse counters for done strobes.
    always @(posedge clk) begin
        if (load_done === 1'b1)   n_ld_mon <= n_ld_mon + 1;
        if (unload_done === 1'b1) n_ud_mon <= n_ud_mon + 1;
    end

    function automatic logic [15:0] exp_rsc();
`ifdef MINV_SEQ_RSCNT_EN
        return 16'(exp_rs);
`else
        return 16'd0;
`endif
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; rs_req = 1'b0;
        unload_start = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            n_tests++;
            if (reg_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", reg_we); end
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; unload_start = 1'b1;
        #1;
        n_tests++;
        if ({in_ready, load_done, unload_done, out_valid, reg_we} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_state: got %b expected 10000", {in_ready, load_done, unload_done, out_valid, reg_we});
        end
        n_tests++;
        if (rs_count !== 16'd0) begin n_fail++; $display("FAIL reset_rscnt: got %0h expected 0", rs_count); end
        @(negedge clk);
        unload_start = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL idle_unload_ignored: got %b expected 01", {out_valid, in_ready}); end
        @(negedge clk);
    endtask

    // Load op from IDLE; then, on the load_done cycle, issue a shift request.
    task automatic load_op(input logic [255:0] op, input bit toggle, input string name);
        int acc = 0;
        int cyc = 0;
        int ld0 = n_ld_mon;
        while (acc < 16 && cyc < 200) begin
            in_valid     = toggle ? ((cyc % 2) == 0) : 1'b1;
            in_data      = op[16*acc +: 16];
            rs_req       = 1'($urandom);
            unload_start = 1'($urandom);
            #1;
            n_tests++;
            if ({in_ready, load_done, out_valid} !== 3'b100) begin
                n_fail++; $display("FAIL %s_ld_ctl: got %b expected 100 (cycle %0d)", name, {in_ready, load_done, out_valid}, cyc);
            end
            n_tests++;
            if ({reg_we, reg_sel_cyc, reg_sel_rs} !== {in_valid, 2'b00}) begin
                n_fail++; $display("FAIL %s_ld_we: got %b expected %b", name, {reg_we, reg_sel_cyc, reg_sel_rs}, {in_valid, 2'b00});
            end
            if (in_valid) acc++;
            cyc++;
            @(negedge clk);
        end
        n_tests++;
        if (cyc != (toggle ? 31 : 16)) begin n_fail++; $display("FAIL %s_ld_cycles: got %0d expected %0d", name, cyc, toggle ? 31 : 16); end
        in_valid = 1'b1; in_data = 16'($urandom); rs_req = 1'b1; unload_start = 1'b1;
        #1;
        n_tests++;
        if ({load_done, in_ready, reg_we, reg_sel_cyc, reg_sel_rs} !== 5'b10101) begin
            n_fail++; $display("FAIL %s_ld_done_cyc: got %b expected 10101", name, {load_done, in_ready, reg_we, reg_sel_cyc, reg_sel_rs});
        end
        n_tests++;
        if (rs_count !== 16'd0) begin n_fail++; $display("FAIL %s_ld_rscnt_clr: got %0h expected 0", name, rs_count); end
        n_tests++;
        if (reg_model !== op) begin n_fail++; $display("FAIL %s_ld_reg: got %h expected %h", name, reg_model, op); end
        @(negedge clk);
        exp_op = op >> 1;
        exp_rs = 1;
        idle_inputs();
        #1;
        n_tests++;
        if ({load_done, out_valid, in_ready} !== 3'b000) begin
            n_fail++; $display("FAIL %s_ld_after: got %b expected 000", name, {load_done, out_valid, in_ready});
        end
        n_tests++;
        if (reg_model !== exp_op) begin n_fail++; $display("FAIL %s_b2b_shift: got %h expected %h", name, reg_model, exp_op); end
        n_tests++;
        if (n_ld_mon - ld0 != 1) begin n_fail++; $display("FAIL %s_ld_pulses: got %0d expected 1", name, n_ld_mon - ld0); end
        @(negedge clk);
    endtask

    // Shift requests in HOLD, with unload_start randomly raised alongside.
    task automatic test_shift();
        int k = $urandom_range(2, 5);
        for (int i = 0; i < k; i++) begin
            rs_req = 1'b1; unload_start = 1'($urandom);
            #1;
            n_tests++;
            if ({reg_we, reg_sel_cyc, reg_sel_rs, in_ready, out_valid} !== 5'b10100) begin
                n_fail++; $display("FAIL shift_ctl: got %b expected 10100", {reg_we, reg_sel_cyc, reg_sel_rs, in_ready, out_valid});
            end
            @(negedge clk);
        end
        exp_op = exp_op >> k;
        exp_rs += k;
        idle_inputs();
        #1;
        n_tests++;
        if ({out_valid, reg_we} !== 2'b00) begin n_fail++; $display("FAIL shift_stay_hold: got %b expected 00", {out_valid, reg_we}); end
        n_tests++;
        if (reg_model !== exp_op) begin n_fail++; $display("FAIL shift_reg: got %h expected %h", reg_model, exp_op); end
        n_tests++;
        if (rs_count !== exp_rsc()) begin n_fail++; $display("FAIL shift_rscnt: got %0d expected %0d", rs_count, exp_rsc()); end
        @(negedge clk);
    endtask

    task automatic test_unload(input bit toggle);
        int idx = 0;
        int cyc = 0;
        int ud0 = n_ud_mon;
        unload_start = 1'b1;
        #1;
        n_tests++;
        if ({reg_we, out_valid} !== 2'b00) begin n_fail++; $display("FAIL unl_start: got %b expected 00", {reg_we, out_valid}); end
        @(negedge clk);
        unload_start = 1'b0;
        while (idx < 16 && cyc < 200) begin
            out_ready = toggle ? ((cyc % 2) == 1) : 1'($urandom);
            rs_req    = 1'($urandom);
            in_valid  = 1'($urandom);
            #1;
            n_tests++;
            if ({out_valid, out_last, in_ready, unload_done} !== {1'b1, (idx == 15), 2'b00}) begin
                n_fail++; $display("FAIL unl_ctl: got %b expected %b (word %0d)", {out_valid, out_last, in_ready, unload_done}, {1'b1, (idx == 15), 2'b00}, idx);
            end
            n_tests++;
            if (out_data !== exp_op[16*idx +: 16]) begin
                n_fail++; $display("FAIL unl_data: got %h expected %h (word %0d)", out_data, exp_op[16*idx +: 16], idx);
            end
            n_tests++;
            if ({reg_we, reg_sel_cyc, reg_sel_rs} !== {out_ready, out_ready, 1'b0}) begin
                n_fail++; $display("FAIL unl_we: got %b expected %b", {reg_we, reg_sel_cyc, reg_sel_rs}, {out_ready, out_ready, 1'b0});
            end
            if (out_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        n_tests++;
        if (idx != 16) begin n_fail++; $display("FAIL unl_timeout: got %0d words expected 16", idx); end
        idle_inputs();
        #1;
        n_tests++;
        if ({unload_done, out_valid} !== 2'b10) begin n_fail++; $display("FAIL unl_done: got %b expected 10", {unload_done, out_valid}); end
        n_tests++;
        if (reg_model !== exp_op) begin n_fail++; $display("FAIL unl_reg_intact: got %h expected %h", reg_model, exp_op); end
        n_tests++;
        if (rs_count !== exp_rsc()) begin n_fail++; $display("FAIL unl_rscnt: got %0d expected %0d", rs_count, exp_rsc()); end
        @(negedge clk);
        #1;
        n_tests++;
        if (unload_done !== 1'b0 || n_ud_mon - ud0 != 1) begin
            n_fail++; $display("FAIL unl_pulse: got level %b count %0d expected 0 and 1", unload_done, n_ud_mon - ud0);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [255:0] op;
        flush = 1'b1; rs_req = 1'b1;
        #1;
        n_tests++;
        if (reg_we !== 1'b0) begin n_fail++; $display("FAIL flush_hold_we: got %b expected 0", reg_we); end
        @(negedge clk);
        idle_inputs();
        exp_rs = 0;
        #1;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10 || rs_count !== 16'd0) begin
            n_fail++; $display("FAIL flush_idle: got %b/%0d expected 10/0", {in_ready, out_valid}, rs_count);
        end
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            exp_op = {in_data, exp_op[255:16]};
            @(negedge clk);
        end
        in_valid = 1'b1; in_data = 16'($urandom); flush = 1'b1;
        #1;
        n_tests++;
        if (reg_we !== 1'b0) begin n_fail++; $display("FAIL flush_load_we: got %b expected 0", reg_we); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_tests++;
        if ({in_ready, load_done} !== 2'b10) begin n_fail++; $display("FAIL flush_load_idle: got %b expected 10", {in_ready, load_done}); end
        n_tests++;
        if (reg_model !== exp_op) begin n_fail++; $display("FAIL flush_reg: got %h expected %h", reg_model, exp_op); end
        @(negedge clk);
        for (int i = 0; i < 16; i++) op[16*i +: 16] = 16'($urandom);
        load_op(op, 1'b0, "post_flush");
    endtask

    task automatic test_reset_mid_unload();
        logic [255:0] op;
        unload_start = 1'b1;
        @(negedge clk);
        unload_start = 1'b0; out_ready = 1'b1;
        repeat (5) @(negedge clk);
        exp_op = {exp_op[79:0], exp_op[255:80]};
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (reg_we !== 1'b0) begin n_fail++; $display("FAIL rst_unl_we: got %b expected 0", reg_we); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        exp_rs = 0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, unload_done} !== 3'b100 || rs_count !== 16'd0) begin
            n_fail++; $display("FAIL rst_unl_idle: got %b/%0d expected 100/0", {in_ready, out_valid, unload_done}, rs_count);
        end
        n_tests++;
        if (reg_model !== exp_op) begin n_fail++; $display("FAIL rst_unl_reg: got %h expected %h", reg_model, exp_op); end
        @(negedge clk);
        for (int i = 0; i < 16; i++) op[16*i +: 16] = 16'($urandom);
        load_op(op, 1'b1, "post_reset");
    endtask

    initial begin
        logic [255:0] op;
        test_reset();
        for (int i = 0; i < 16; i++) op[16*i +: 16] = 16'(i + 1);
        load_op(op, 1'b0, "seq_load");
        test_shift();
        test_unload(1'b1);
        test_shift();
        test_unload(1'b0);
        test_flush();
        test_shift();
        test_reset_mid_unload();
        test_unload(1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
